// File: rtl/video2ram_pkg.sv
// Shared types and defaults for the video-to-RAM capture writer.
package video2ram_pkg;

  localparam int   PIX_W            = 24;
  localparam int   RAM_AW           = 15;
  localparam logic HSYNC_ACTIVE_DEF = 1'b0;
  localparam logic VSYNC_ACTIVE_DEF = 1'b0;

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    FILL,
    RUN
  } wr_state_t;

  // Capture window and ring geometry; also used by the config register block.
  typedef struct packed {
    logic [11:0]       x_start;
    logic [11:0]       x_end;
    logic [11:0]       y_start;
    logic [11:0]       y_end;
    logic [9:0]        line_len;
    logic [RAM_AW-1:0] numwords;
    logic [7:0]        trigger_line;
  } capture_cfg_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/video2ram_if.sv
// Pixel stream in, RAM write port out.
interface video2ram_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 24
);
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] indata;
  logic                  in_hsync;
  logic                  in_vsync;
  logic [DATA_WIDTH-1:0] wrdata;
  logic [ADDR_WIDTH-1:0] wraddr;
  logic                  wren;

  modport master (
    output pixel_valid, indata, in_hsync, in_vsync,
    input  wrdata, wraddr, wren
  );

  modport slave (
    input  pixel_valid, indata, in_hsync, in_vsync,
    output wrdata, wraddr, wren
  );
endinterface

// File: rtl/video2ram_sync_edge_detect.sv
// Registers a sync input and flags the cycle it first reaches its asserted level.
module sync_edge_detect #(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_in,
  output logic act_edge
);
  logic sync_q;
  logic sync_prev;

  // Two-deep history; reset to the inactive level so no edge fires out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= ~ACTIVE;
      sync_prev <= ~ACTIVE;
    end else begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
    end
  end

  assign act_edge = (sync_q == ACTIVE) && (sync_prev != ACTIVE);
endmodule

// File: rtl/video2ram.sv
// Capture-side writer: windows the pixel stream into a line-granular RAM ring
// and raises starttrigger once enough lines of a frame are buffered.
module video2ram
  import video2ram_pkg::*;
#(
  parameter int   ADDR_WIDTH   = 15,
  parameter int   DATA_WIDTH   = PIX_W,
  parameter logic HSYNC_ACTIVE = HSYNC_ACTIVE_DEF,
  parameter logic VSYNC_ACTIVE = VSYNC_ACTIVE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  video2ram_if.slave            bus,
  input  logic [11:0]           capture_x_start,
  input  logic [11:0]           capture_x_end,
  input  logic [11:0]           capture_y_start,
  input  logic [11:0]           capture_y_end,
  input  logic [9:0]            buffer_line_length,
  input  logic [ADDR_WIDTH-1:0] ram_numwords,
  input  logic [7:0]            trigger_line,
  output logic                  starttrigger,
  output logic [11:0]           lines_per_frame,
  output logic                  resync
);
  capture_cfg_t cfg;
  assign cfg = '{x_start: capture_x_start, x_end: capture_x_end,
                 y_start: capture_y_start, y_end: capture_y_end,
                 line_len: buffer_line_length, numwords: RAM_AW'(ram_numwords),
                 trigger_line: trigger_line};

  // Stage 1: pixel and enable registers; syncs go through the edge detectors.
  logic                  pv_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  hs_e, vs_e;

  // Sample the pixel bus every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv_q   <= 1'b0;
      data_q <= '0;
    end else begin
      pv_q   <= bus.pixel_valid;
      data_q <= bus.indata;
    end
  end

  sync_edge_detect #(.ACTIVE(HSYNC_ACTIVE)) u_hs (
    .clock(clock), .reset(reset), .sync_in(bus.in_hsync), .act_edge(hs_e));
  sync_edge_detect #(.ACTIVE(VSYNC_ACTIVE)) u_vs (
    .clock(clock), .reset(reset), .sync_in(bus.in_vsync), .act_edge(vs_e));

  // Stage 2: raster counters, ring addressing, trigger FSM, RAM write port.
  wr_state_t             state;
  logic [11:0]           cnt_x, cnt_y;
  logic [9:0]            addr_x;
  logic [ADDR_WIDTH-1:0] addr_y;
  logic [7:0]            line_cnt;
  logic                  line_wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;

  logic                  capture;
  logic [ADDR_WIDTH:0]   y_sum;
  logic [ADDR_WIDTH-1:0] y_next;
  logic [10:0]           x_inc;

  assign capture = pv_q && (state != WAIT_VSYNC)
                && (cnt_x >= cfg.x_start) && (cnt_x < cfg.x_end)
                && (cnt_y >= cfg.y_start) && (cnt_y < cfg.y_end);
  // Wrap decision uses the unwrapped sum so an overflowing add still wraps.
  assign y_sum  = {1'b0, addr_y} + (ADDR_WIDTH+1)'(cfg.line_len);
  assign y_next = (y_sum >= (ADDR_WIDTH+1)'(cfg.numwords)) ? '0 : y_sum[ADDR_WIDTH-1:0];
  assign x_inc  = {1'b0, addr_x} + 11'd1;

  // Sync edges take priority over pixels; vsync beats a coincident hsync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= WAIT_VSYNC;
      cnt_x           <= '0;
      cnt_y           <= '0;
      addr_x          <= '0;
      addr_y          <= '0;
      line_cnt        <= '0;
      line_wr         <= 1'b0;
      wr_data         <= '0;
      wr_addr         <= '0;
      wr_en           <= 1'b0;
      starttrigger    <= 1'b0;
      lines_per_frame <= '0;
      resync          <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      resync <= 1'b0;
      if (vs_e) begin
        lines_per_frame <= cnt_y;
        resync          <= (cnt_y != lines_per_frame) && (lines_per_frame != '0);
        cnt_x           <= '0;
        cnt_y           <= '0;
        addr_x          <= '0;
        addr_y          <= '0;
        line_wr         <= 1'b0;
        line_cnt        <= '0;
        if (state == WAIT_VSYNC) begin
          if (cfg.trigger_line == '0) begin
            starttrigger <= 1'b1;
            state        <= RUN;
          end else begin
            state <= FILL;
          end
        end
      end else if (hs_e) begin
        cnt_x   <= '0;
        cnt_y   <= sat_inc12(cnt_y);
        addr_x  <= '0;
        line_wr <= 1'b0;
        if (line_wr) begin
          addr_y <= y_next;
          if (state == FILL) begin
            line_cnt <= line_cnt + 8'd1;
            if ({1'b0, line_cnt} + 9'd1 >= {1'b0, cfg.trigger_line}) begin
              starttrigger <= 1'b1;
              state        <= RUN;
            end
          end
        end
      end else if (pv_q) begin
        cnt_x <= sat_inc12(cnt_x);
        if (capture) begin
          wr_en   <= 1'b1;
          wr_data <= data_q;
          wr_addr <= addr_y + ADDR_WIDTH'(addr_x);
          line_wr <= 1'b1;
          // Excess pixels keep landing on the last word of the line.
          if (x_inc < {1'b0, cfg.line_len}) addr_x <= x_inc[9:0];
        end
      end
    end
  end

  assign bus.wrdata = wr_data;
  assign bus.wraddr = wr_addr;
  assign bus.wren   = wr_en;
endmodule

// File: tb/tb_video2ram.sv
// Scoreboard bench for video2ram: a frame-level reference model predicts every
// RAM write and the per-cycle trigger/line-count outputs two cycles ahead.
module tb_video2ram;
  localparam logic SY_ACT = 1'b0;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] cfg_xs, cfg_xe, cfg_ys, cfg_ye;
  logic [9:0]  cfg_len;
  logic [14:0] cfg_nw;
  logic [7:0]  cfg_trig;
  logic        starttrigger, resync;
  logic [11:0] lines_per_frame;

  video2ram_if #(.ADDR_WIDTH(15), .DATA_WIDTH(24)) bus ();

  video2ram dut (
    .clock(clock), .reset(reset), .bus(bus),
    .capture_x_start(cfg_xs), .capture_x_end(cfg_xe),
    .capture_y_start(cfg_ys), .capture_y_end(cfg_ye),
    .buffer_line_length(cfg_len), .ram_numwords(cfg_nw), .trigger_line(cfg_trig),
    .starttrigger(starttrigger), .lines_per_frame(lines_per_frame), .resync(resync)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int tag; logic [14:0] addr; logic [23:0] data; } wr_exp_t;
  typedef struct { int tag; logic st; logic [11:0] lpf; logic rs; } st_exp_t;
  wr_exp_t wq[$];
  st_exp_t sq[$];

  int n_chk = 0, n_fail = 0;

  // Reference model: raster position, captured-line slot within frame, trigger.
  int m_x, m_y, m_slot, m_pix, m_lpf;
  bit m_st, m_rs, m_armed;
  logic m_hs_prev, m_vs_prev;

  // Monitor-side counters and probe.
  bit cnt_en = 0;
  int wr_count = 0;
  int probe_hits = 0;
  logic [14:0] probe_addr = '0;
  wr_exp_t we;
  st_exp_t se;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_slot = 0; m_pix = 0; m_lpf = 0;
    m_st = 0; m_rs = 0; m_armed = 0;
    m_hs_prev = ~SY_ACT; m_vs_prev = ~SY_ACT;
  endtask

  task automatic model_step(input logic pv, input logic [23:0] d, input logic hs, input logic vs);
    bit hs_e, vs_e;
    wr_exp_t w;
    st_exp_t s;
    int len, nw;
    len = int'(cfg_len);
    nw  = int'(cfg_nw);
    hs_e = (hs == SY_ACT) && (m_hs_prev != SY_ACT);
    vs_e = (vs == SY_ACT) && (m_vs_prev != SY_ACT);
    m_hs_prev = hs;
    m_vs_prev = vs;
    m_rs = 0;
    if (vs_e) begin
      m_rs = (m_y != m_lpf) && (m_lpf != 0);
      m_lpf = m_y; m_y = 0; m_x = 0; m_slot = 0; m_pix = 0; m_armed = 1;
    end else if (hs_e) begin
      if (m_pix > 0) m_slot++;
      m_pix = 0; m_x = 0;
      if (m_y < 4095) m_y++;
    end else if (pv) begin
      if (m_armed && m_x >= int'(cfg_xs) && m_x < int'(cfg_xe)
          && m_y >= int'(cfg_ys) && m_y < int'(cfg_ye)) begin
        w.tag  = cyc + 2;
        w.addr = 15'(((m_slot * len) % nw) + ((m_pix < len - 1) ? m_pix : len - 1));
        w.data = d;
        wq.push_back(w);
        m_pix++;
      end
      if (m_x < 4095) m_x++;
    end
    if (m_armed && m_slot >= int'(cfg_trig)) m_st = 1;
    s.tag = cyc + 2; s.st = m_st; s.lpf = 12'(m_lpf); s.rs = m_rs;
    sq.push_back(s);
  endtask

  task automatic drive(input logic pv, input logic hs_a, input logic vs_a);
    logic [23:0] d;
    d = {m_y[7:0], m_x[11:0], 4'($urandom)};
    bus.pixel_valid = pv;
    bus.indata      = d;
    bus.in_hsync    = hs_a ? SY_ACT : ~SY_ACT;
    bus.in_vsync    = vs_a ? SY_ACT : ~SY_ACT;
    model_step(pv, d, bus.in_hsync, bus.in_vsync);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.pixel_valid = 1'b0; bus.indata = '0;
    bus.in_hsync = ~SY_ACT; bus.in_vsync = ~SY_ACT;
    wq.delete(); sq.delete();
    model_reset();
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  task automatic set_cfg(input int xs, input int xe, input int ys, input int ye,
                         input int len, input int nw, input int trig);
    idle(2);
    cfg_xs = 12'(xs); cfg_xe = 12'(xe); cfg_ys = 12'(ys); cfg_ye = 12'(ye);
    cfg_len = 10'(len); cfg_nw = 15'(nw); cfg_trig = 8'(trig);
    idle(1);
  endtask

  // pv_mode: 0 continuous, 1 random, 2 every other cycle; line ends in an hsync pulse.
  task automatic run_line(input int npix, input int pv_mode);
    logic pv;
    for (int i = 0; i < npix; i++) begin
      case (pv_mode)
        0:       pv = 1'b1;
        1:       pv = ($urandom_range(0, 3) != 0);
        default: pv = (i % 2 == 0);
      endcase
      drive(pv, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse(input logic with_h);
    drive(1'b0, with_h, 1'b1);
    drive(1'b0, with_h, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int nlines, input int npix, input int pv_mode);
    vsync_pulse(1'b0);
    for (int i = 0; i < nlines; i++) run_line(npix, pv_mode);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: zero outputs under reset, otherwise pop and compare expectations.
  always @(negedge clock) begin
    if (reset) begin
      n_chk++;
      if (bus.wren || bus.wrdata != '0 || bus.wraddr != '0 || starttrigger
          || lines_per_frame != '0 || resync) begin
        n_fail++;
        $display("FAIL reset_state: wren=%0b wrdata=%h wraddr=%0d st=%0b lpf=%0d resync=%0b, required all zero",
                 bus.wren, bus.wrdata, bus.wraddr, starttrigger, lines_per_frame, resync);
      end
    end else begin
      while (wq.size() > 0 && wq[0].tag < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missing_write: cycle %0d addr=%0d data=%h not written", wq[0].tag, wq[0].addr, wq[0].data);
        void'(wq.pop_front());
      end
      if (bus.wren) begin
        if (cnt_en) wr_count++;
        if (cnt_en && bus.wrdata[23:4] == {8'd2, 12'd5}) begin
          probe_hits++;
          probe_addr = bus.wraddr;
        end
        n_chk++;
        if (wq.size() == 0 || wq[0].tag != cyc) begin
          n_fail++;
          $display("FAIL spurious_write: cycle %0d addr=%0d data=%h, required no write", cyc, bus.wraddr, bus.wrdata);
        end else begin
          we = wq.pop_front();
          if (bus.wraddr != we.addr || bus.wrdata != we.data) begin
            n_fail++;
            $display("FAIL write: cycle %0d addr=%0d data=%h, required addr=%0d data=%h",
                     cyc, bus.wraddr, bus.wrdata, we.addr, we.data);
          end
        end
      end
      while (sq.size() > 0 && sq[0].tag < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL status_order: stale expectation for cycle %0d at cycle %0d", sq[0].tag, cyc);
        void'(sq.pop_front());
      end
      if (sq.size() > 0 && sq[0].tag == cyc) begin
        se = sq.pop_front();
        n_chk++;
        if (starttrigger != se.st || lines_per_frame != se.lpf || resync != se.rs) begin
          n_fail++;
          $display("FAIL status: cycle %0d st=%0b lpf=%0d resync=%0b, required st=%0b lpf=%0d resync=%0b",
                   cyc, starttrigger, lines_per_frame, resync, se.st, se.lpf, se.rs);
        end
      end
    end
  end

  initial begin
    cfg_xs = 12'd0; cfg_xe = 12'd640; cfg_ys = 12'd0; cfg_ye = 12'd480;
    cfg_len = 10'd640; cfg_nw = 15'd23040; cfg_trig = 8'd16;
    do_reset(3);

    // Full-width window: a line before the first vsync must not write.
    cnt_en = 1;
    run_line(50, 0);
    vsync_pulse(1'b0);
    for (int i = 0; i < 3; i++) run_line(800, 0);
    idle(4);
    cnt_en = 0;
    check("writes_640_per_line", wr_count, 3 * 640);
    check("probe_x5_y2_hits", probe_hits, 1);
    check("probe_x5_y2_addr", int'(probe_addr), 1285);

    // Small ring: trigger, wrap, overlong lines, line-count change.
    set_cfg(2, 20, 1, 40, 16, 80, 4);
    for (int f = 0; f < 3; f++) frame(12, 30, 1);
    frame(11, 30, 1);
    vsync_pulse(1'b0);
    idle(3);
    check("lines_per_frame_after_short", int'(lines_per_frame), 11);
    check("trigger_sticky_after_resync", int'(starttrigger), 1);

    // Reset mid-line: no writes until vsync, trigger rebuilt from scratch.
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b0);
    do_reset(3);
    for (int i = 0; i < 2; i++) run_line(30, 1);
    frame(8, 30, 1);
    idle(3);
    check("trigger_after_reset_refill", int'(starttrigger), 1);

    // Alternating valid, narrow window; then coincident hsync/vsync edges.
    set_cfg(100, 110, 0, 40, 16, 80, 2);
    wr_count = 0;
    cnt_en = 1;
    frame(3, 240, 2);
    vsync_pulse(1'b1);
    for (int i = 0; i < 2; i++) run_line(240, 2);
    idle(4);
    cnt_en = 0;
    check("narrow_window_writes", wr_count, 50);

    // Degenerate window after reset: no writes, no trigger.
    do_reset(2);
    set_cfg(50, 50, 0, 40, 16, 80, 2);
    wr_count = 0;
    cnt_en = 1;
    frame(4, 30, 1);
    frame(3, 30, 1);
    idle(4);
    cnt_en = 0;
    check("degenerate_writes", wr_count, 0);
    check("degenerate_trigger", int'(starttrigger), 0);

    check("scoreboard_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video2ram.md
Name: video2ram

Overview:
- Capture-side writer for the HDMI line ring buffer.
- Samples the Dreamcast 24-bit pixel stream with its syncs and derives input X/Y counters from the sync edges.
- Writes pixels inside the configured capture window into the dual-port RAM's write port as a line-granular ring.
- Raises starttrigger once enough lines are buffered; the downstream RAM-to-HDMI output stage waits on it before starting its raster.

Parameters:
- ADDR_WIDTH, 15, RAM word-address width; must match the output stage's rdaddr.
- DATA_WIDTH, 24, pixel width, packed {R[7:0],G[7:0],B[7:0]}.
- HSYNC_ACTIVE, 1'b0, input hsync asserted level.
- VSYNC_ACTIVE, 1'b0, input vsync asserted level.

Ports:
- clock  in  1  input pixel clock domain (also RAM write clock)
- reset  in  1  asynchronous, active-high
- pixel_valid  in  1  clock enable, one input pixel per asserted cycle
- indata  in  24  input pixel
- in_hsync  in  1  input horizontal sync
- in_vsync  in  1  input vertical sync
- capture_x_start  in  12  first captured pixel index in line (inclusive)
- capture_x_end  in  12  end pixel index (exclusive)
- capture_y_start  in  12  first captured line (inclusive)
- capture_y_end  in  12  end line (exclusive)
- buffer_line_length  in  10  words per buffered line
- ram_numwords  in  15  ring size in words, a multiple of buffer_line_length
- trigger_line  in  8  captured lines required before starttrigger
- wrdata  out  24  RAM write data
- wraddr  out  15  RAM write address
- wren  out  1  RAM write enable
- starttrigger  out  1  sticky start indication to the output stage
- lines_per_frame  out  12  line count of the last complete frame
- resync  out  1  one-cycle pulse when the frame line count changes

Behaviour:
- Reset, asynchronous:
  - wren=0, wrdata=0, wraddr=0, starttrigger=0, lines_per_frame=0, resync=0.
  - All counters=0.
  - State=WAIT_VSYNC.
  - Sync history registers take the inactive levels.
- Stage 1 registers indata, pixel_valid and the syncs, then edge-detects the syncs. An active edge is the transition to the asserted level.
- hsync active edge:
  - counterX<=0.
  - counterY<=counterY+1, saturating at 4095.
  - If the line just ended was a captured line, addrY<=addrY+buffer_line_length; if that result ≥ ram_numwords, addrY<=0 (ring wrap).
  - addrX<=0.
- vsync active edge:
  - lines_per_frame<=counterY.
  - resync=1 for one cycle if the new value differs from the previous value and the previous value is nonzero.
  - counterY<=0, addrY<=0, addrX<=0.
- Simultaneous hsync and vsync edges: the vsync action wins.
- Pixel counting:
  - On a registered pixel_valid, counterX increments, saturating at 4095.
  - The pixel is captured when x_start ≤ counterX < x_end and y_start ≤ counterY < y_end and state≠WAIT_VSYNC.
  - When captured: wren=1 next cycle, wrdata=pixel, wraddr=addrY+addrX.
  - After a capture, addrX increments, but is held at buffer_line_length-1 once it reaches that value (excess pixels overwrite the last word).
- Latency: a pixel presented on indata with pixel_valid at cycle n appears on wrdata/wraddr/wren at cycle n+2. wren is deasserted on every non-captured cycle.
- State machine:
  - WAIT_VSYNC: no writes; on vsync edge go to FILL.
  - FILL: writes enabled. Count completed captured lines; when count reaches trigger_line, set starttrigger=1 and go to RUN. If trigger_line=0, starttrigger is set on entry to FILL.
  - RUN: writes continue. starttrigger stays 1 until reset; resync does not clear it.
- A vsync edge during FILL restarts the line count; starttrigger cannot assert before trigger_line full lines exist within one frame.
- Reset mid-line: the writer returns to WAIT_VSYNC and no write occurs until the next vsync edge.
- Window degenerate (start ≥ end): never writes, never triggers.
- All address arithmetic is unsigned, 15-bit; the addrY+buffer_line_length sum is compared before wrapping (16-bit intermediate).

Decomposition:
- Shared package: pixel width constant; sync polarity defaults; capture-config typedef bundling the x/y start/end, buffer_line_length, ram_numwords and trigger_line fields. This typedef is also referenced by the top-level config register block.
- Sub-module sync_edge_detect (register + active-edge pulse, polarity parameter), instantiated twice.

Test Plan:
- Window 0..640 x 0..480, len 640, numwords 23040, 800-pixel lines, vsync every 525 lines → pixel (x=5,y=2) written at wraddr 1285, wren high for exactly 640 cycles/line, data two cycles delayed.
- trigger_line=16 → starttrigger rises within the first frame right after line 15 completes (the 16th captured line), stays 1 over three frames.
- Ring wrap: numwords 23040 → after 36 captured lines the next line starts at wraddr 0; the last word before wrap is 23039.
- Frames of 525 lines then one frame of 524 → lines_per_frame 525 then 524, exactly one resync pulse; starttrigger remains 1.
- Reset asserted at x=300,y=100 → outputs zero immediately, no wren until the vsync edge, starttrigger re-asserts only after 16 new lines.
- pixel_valid toggling every other cycle, x window 100..110 → exactly 10 writes to addrX 0..9; the hsync/vsync same-cycle edge case resets Y to 0.
